fpga_mem_responder: RTL
=======================

FPGA_MEM_RESPONDER -- requirements
Module: fpga_mem_responder

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- NOC_W, 64, NoC flit width.
- MEM_DEPTH, 1024, RAM depth in 64-bit words.
- MEM_DEPTH_LOG, 10, address index width.
- LINE_FLITS, 32, data flits per line (2048 bits).
- RD_TYPE, 8'd19, load request type.
- WR_TYPE, 8'd20, store request type.
- RD_ACK_TYPE, 8'd24, load response type.
- WR_ACK_TYPE, 8'd25, store ack type.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- noc2_in_val, in, 1, request flit valid.
- noc2_in_data, in, NOC_W, request flit.
- noc2_in_rdy, out, 1, request flit accepted.
- noc3_out_val, out, 1, response flit valid.
- noc3_out_data, out, NOC_W, response flit.
- noc3_out_rdy, in, 1, downstream ready.
- busy, out, 1, high when state is not IDLE.
- err_oob, out, 1, sticky out-of-range flag.
REQ-003 Header flit 1 fields: length [29:22], type [21:14], tag [11:6]; flit 2 address [31:0]; flit 3 ignored; word index = addr[MEM_DEPTH_LOG+2:3].

Function
REQ-004 A flit transfers on a port only in a cycle where val and rdy are both high; the block SHALL NOT depend on val being gated by rdy.
REQ-005 FSM states: IDLE, HDR2, HDR3, WR_DATA, WR_ACK, RD_HDR, RD_DATA, DROP.
- IDLE: noc2_in_rdy=1. On a transfer, latch length, type and tag, then go to HDR2.
- HDR2: on a transfer, latch the address and go to HDR3.
- HDR3: on a transfer, go to WR_DATA if type==WR_TYPE, RD_HDR if type==RD_TYPE, else DROP.
REQ-006 WR_DATA: each accepted flit is written to RAM at index+count; count is 6-bit and starts at 0.
- After LINE_FLITS flits, go to WR_ACK.
- noc2_in_rdy=0 in every state except IDLE, HDR2, HDR3, WR_DATA and DROP.
REQ-007 WR_ACK: drive one flit with length 0, type WR_ACK_TYPE and the latched tag; go to IDLE on a transfer.
REQ-008 RD_HDR: drive a header flit with length LINE_FLITS, type RD_ACK_TYPE and the latched tag; go to RD_DATA on a transfer.
REQ-009 RD_DATA: drive RAM words index..index+LINE_FLITS-1 in order.
- Hold data stable while noc3_out_rdy=0.
- Sustain one flit per cycle while noc3_out_rdy=1.
- Go to IDLE after the last transfer.
REQ-010 Address arithmetic SHALL wrap modulo MEM_DEPTH when MEM_RESP_BOUNDS_CHECK_EN is undefined.
REQ-011 DROP: consume (length-2) further flits, then return to IDLE. Length <= 2 returns to IDLE immediately. No response is sent.
REQ-012 noc3_out_val and noc3_out_data SHALL be registered outputs; noc3_out_data=0 whenever noc3_out_val=0.

Reset
REQ-013 On rst: state=IDLE, counters=0, noc3_out_val=0, noc3_out_data=0, err_oob=0, busy=0. RAM contents are unchanged.
REQ-014 rst mid-packet SHALL abandon the packet; the first flit accepted after reset is decoded as header flit 1.

Configuration
REQ-015 Macro MEM_RESP_BOUNDS_CHECK_EN.
- Defined: if index+LINE_FLITS > MEM_DEPTH, suppress all RAM writes, return zero data flits, and set err_oob (cleared only by rst). Response flits and the ack are still sent.
- Undefined: no check; err_oob is tied to 0 and addresses wrap (REQ-010).

Verification
REQ-016 Write of 32 flits with value i at addr 0x100, tag 5 -> one ack flit with type 25, tag 5, length 0; RAM[32+i]=i.
REQ-017 Read of addr 0x100, tag 7, after REQ-016 -> header flit with length 32, type 24, tag 7, then 32 data flits 0..31 in order.
REQ-018 Read with noc3_out_rdy toggling every cycle -> no flit is lost or duplicated; data is stable while rdy=0.
REQ-019 Header with type 8'd99 and length 5 -> 3 flits consumed, no response, next read served correctly.
REQ-020 Write at word index 1000 with the macro defined -> err_oob=1, RAM unchanged, ack sent; without the macro -> data wraps to indices 1000..1023 and 0..7.
REQ-021 rst asserted after 10 write data flits, then a fresh read -> read is served correctly, busy=0 in the cycle after reset.

Source files
------------

// File: rtl/fpga_mem_responder.sv
// NoC memory responder: accepts 3-flit load/store headers, serves 32-flit lines from block RAM.
// Optional build macro MEM_RESP_BOUNDS_CHECK_EN enables line range checking and the sticky err_oob flag.
module fpga_mem_responder #(
    parameter int         NOC_W         = 64,
    parameter int         MEM_DEPTH     = 1024,
    parameter int         MEM_DEPTH_LOG = 10,
    parameter int         LINE_FLITS    = 32,
    parameter logic [7:0] RD_TYPE       = 8'd19,
    parameter logic [7:0] WR_TYPE       = 8'd20,
    parameter logic [7:0] RD_ACK_TYPE   = 8'd24,
    parameter logic [7:0] WR_ACK_TYPE   = 8'd25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             noc2_in_val,
    input  logic [NOC_W-1:0] noc2_in_data,
    output logic             noc2_in_rdy,
    output logic             noc3_out_val,
    output logic [NOC_W-1:0] noc3_out_data,
    input  logic             noc3_out_rdy,
    output logic             busy,
    output logic             err_oob
);

    localparam int CNT_W = $clog2(LINE_FLITS) + 1;

    typedef enum logic [2:0] {
        IDLE, HDR2, HDR3, WR_DATA, WR_ACK, RD_HDR, RD_DATA, DROP
    } state_t;

    state_t                   state_reg;
    logic [7:0]               len_reg;
    logic [7:0]               type_reg;
    logic [5:0]               tag_reg;
    logic [MEM_DEPTH_LOG-1:0] index_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic [7:0]               drop_left_reg;
    logic                     out_val_reg;
    logic [NOC_W-1:0]         out_data_reg;

    logic [NOC_W-1:0]         mem [MEM_DEPTH];
    logic [NOC_W-1:0]         ram_q_reg;

    logic                     in_fire;
    logic                     out_fire;
    logic                     last_word;
    logic                     rd_load;
    logic                     wr_en;
    logic [MEM_DEPTH_LOG-1:0] wr_addr;
    logic [MEM_DEPTH_LOG-1:0] rd_addr;
    logic [NOC_W-1:0]         rd_word;

    function automatic logic [NOC_W-1:0] resp_hdr(input logic [7:0] len,
                                                  input logic [7:0] typ,
                                                  input logic [5:0] tag);
        logic [NOC_W-1:0] h;
        h        = '0;
        h[29:22] = len;
        h[21:14] = typ;
        h[11:6]  = tag;
        return h;
    endfunction

    assign noc2_in_rdy   = (state_reg == IDLE) || (state_reg == HDR2) || (state_reg == HDR3) ||
                           (state_reg == WR_DATA) || (state_reg == DROP);
    assign busy          = (state_reg != IDLE);
    assign noc3_out_val  = out_val_reg;
    assign noc3_out_data = out_data_reg;

    assign in_fire   = noc2_in_val && noc2_in_rdy;
    assign out_fire  = out_val_reg && noc3_out_rdy;
    assign last_word = (cnt_reg == CNT_W'(LINE_FLITS));

    // ram_q_reg must always hold the word that the next output load will take,
    // so the read address looks one word ahead in the cycle a load happens.
    assign rd_load = out_fire && ((state_reg == RD_HDR) || ((state_reg == RD_DATA) && !last_word));
    assign rd_addr = index_reg + MEM_DEPTH_LOG'(cnt_reg + CNT_W'(rd_load));
    assign wr_addr = index_reg + MEM_DEPTH_LOG'(cnt_reg);

`ifdef MEM_RESP_BOUNDS_CHECK_EN
    logic oob_reg;
    logic err_oob_reg;
    logic hdr_oob;

    assign hdr_oob = (32'(noc2_in_data[MEM_DEPTH_LOG+2:3]) + 32'(LINE_FLITS)) > 32'(MEM_DEPTH);
    assign wr_en   = (state_reg == WR_DATA) && in_fire && !oob_reg;
    assign rd_word = oob_reg ? '0 : ram_q_reg;
    assign err_oob = err_oob_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            oob_reg     <= 1'b0;
            err_oob_reg <= 1'b0;
        end else begin
            if (state_reg == HDR2 && in_fire)
                oob_reg <= hdr_oob;
            if (state_reg == HDR3 && in_fire && oob_reg &&
                (type_reg == WR_TYPE || type_reg == RD_TYPE))
                err_oob_reg <= 1'b1;
        end
    end
`else
    assign wr_en   = (state_reg == WR_DATA) && in_fire;
    assign rd_word = ram_q_reg;
    assign err_oob = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= noc2_in_data;
        ram_q_reg <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            type_reg      <= '0;
            tag_reg       <= '0;
            index_reg     <= '0;
            cnt_reg       <= '0;
            drop_left_reg <= '0;
            out_val_reg   <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (in_fire) begin
                        len_reg   <= noc2_in_data[29:22];
                        type_reg  <= noc2_in_data[21:14];
                        tag_reg   <= noc2_in_data[11:6];
                        state_reg <= HDR2;
                    end
                end
                HDR2: begin
                    if (in_fire) begin
                        index_reg <= noc2_in_data[MEM_DEPTH_LOG+2:3];
                        state_reg <= HDR3;
                    end
                end
                HDR3: begin
                    if (in_fire) begin
                        if (type_reg == WR_TYPE) begin
                            state_reg <= WR_DATA;
                        end else if (type_reg == RD_TYPE) begin
                            out_val_reg  <= 1'b1;
                            out_data_reg <= resp_hdr(8'(LINE_FLITS), RD_ACK_TYPE, tag_reg);
                            state_reg    <= RD_HDR;
                        end else if (len_reg > 8'd2) begin
                            drop_left_reg <= len_reg - 8'd2;
                            state_reg     <= DROP;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                WR_DATA: begin
                    if (in_fire) begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_W'(LINE_FLITS - 1)) begin
                            out_val_reg  <= 1'b1;
                            out_data_reg <= resp_hdr(8'd0, WR_ACK_TYPE, tag_reg);
                            state_reg    <= WR_ACK;
                        end
                    end
                end
                WR_ACK: begin
                    if (out_fire) begin
                        out_val_reg  <= 1'b0;
                        out_data_reg <= '0;
                        state_reg    <= IDLE;
                    end
                end
                RD_HDR: begin
                    if (out_fire) begin
                        out_data_reg <= rd_word;
                        cnt_reg      <= cnt_reg + 1'b1;
                        state_reg    <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (out_fire) begin
                        if (last_word) begin
                            out_val_reg  <= 1'b0;
                            out_data_reg <= '0;
                            state_reg    <= IDLE;
                        end else begin
                            out_data_reg <= rd_word;
                            cnt_reg      <= cnt_reg + 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (in_fire) begin
                        drop_left_reg <= drop_left_reg - 8'd1;
                        if (drop_left_reg == 8'd1)
                            state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
